// File: rtl/bfly_out_port_sched.sv
// Output-port packet scheduler for the butterfly switch: two-class arbitration
// (priority first, round-robin within a class), packet-long mux hold, a
// starvation guard on the priority class and a payload-length watchdog.
module bfly_out_port_sched #(
    parameter int unsigned PORTS       = 4,
    parameter int unsigned MAX_PAYLOAD = 15,
    parameter int unsigned PRI_BURST   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            r_adr,
    input  logic [PORTS-1:0][3:0] in_ch_hdr_msn,
    input  logic [PORTS-1:0]      priority_field,
    input  logic                  out_ready,
    output logic [PORTS-1:0]      sel,
    output logic                  shift,
    output logic                  busy,
    output logic [1:0]            owner,
    output logic                  timeout_err
);

    // Channel index width is tied to the 2-bit destination field (PORTS = 4).
    localparam int unsigned IDX_W = 2;
    localparam int unsigned PKT_W = 8;
    localparam int unsigned PRI_W = 4;
    localparam logic [1:0]  TYPE_HDR = 2'b11;
    localparam logic [1:0]  TYPE_PAY = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PRI_W-1:0]   pri_cnt_q, pri_cnt_d;
    logic [PKT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [PKT_W-1:0]   pkt_cnt_inc;
    logic               timeout_q, timeout_d;

    logic [PORTS-1:0]   req;
    logic [PORTS-1:0]   pri_req;
    logic [PORTS-1:0]   nrm_req;
    logic [PORTS-1:0]   cand;
    logic               take_pri;
    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [PORTS-1:0]   sel_c;
    logic               shift_c;

    // Request decode: header flits addressed to this port.
    always_comb begin
        req = '0;
        for (int i = 0; i < int'(PORTS); i++) begin
            req[i] = (in_ch_hdr_msn[i][3:2] == TYPE_HDR) &&
                     (in_ch_hdr_msn[i][1:0] == r_adr);
        end
    end

    assign pri_req = req & priority_field;
    assign nrm_req = req & ~priority_field;

    // Priority class wins unless its burst budget is spent while normal traffic waits.
    assign take_pri = (|pri_req) && ((pri_cnt_q < PRI_W'(PRI_BURST)) || !(|nrm_req));
    assign cand     = take_pri ? pri_req : nrm_req;

    // Round-robin scan of the chosen class starting at rr_ptr (2-bit add wraps mod 4).
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < int'(PORTS); k++) begin
            if (!found && cand[rr_ptr_q + IDX_W'(k)]) begin
                winner = rr_ptr_q + IDX_W'(k);
                found  = 1'b1;
            end
        end
    end

    assign pkt_cnt_inc = pkt_cnt_q + PKT_W'(1);

    // Next-state and combinational mux select / shift.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        pri_cnt_d = pri_cnt_q;
        pkt_cnt_d = pkt_cnt_q;
        timeout_d = 1'b0;
        sel_c     = '0;
        shift_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (out_ready && found) begin
                    sel_c[winner] = 1'b1;
                    shift_c       = 1'b1;
                    owner_d       = winner;
                    rr_ptr_d      = winner + IDX_W'(1);
                    pkt_cnt_d     = '0;
                    state_d       = ST_BUSY;
                    if (take_pri && (|nrm_req)) begin
                        pri_cnt_d = (pri_cnt_q >= PRI_W'(PRI_BURST)) ?
                                    PRI_W'(PRI_BURST) : pri_cnt_q + PRI_W'(1);
                    end else begin
                        pri_cnt_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (in_ch_hdr_msn[owner_q][3:2] == TYPE_PAY) begin
                    if (out_ready) begin
                        sel_c[owner_q] = 1'b1;
                        pkt_cnt_d      = pkt_cnt_inc;
                        // The payload reaching the limit is still forwarded, then the port frees.
                        if (pkt_cnt_inc == PKT_W'(MAX_PAYLOAD)) begin
                            state_d   = ST_IDLE;
                            timeout_d = 1'b1;
                        end
                    end
                end else begin
                    // Header or null from the owner terminates the packet; no same-cycle re-grant.
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            pri_cnt_q <= '0;
            pkt_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            pri_cnt_q <= pri_cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Mux controls are held low while reset is asserted.
    assign sel         = rst_n ? sel_c : '0;
    assign shift       = rst_n & shift_c;
    assign busy        = (state_q == ST_BUSY);
    assign owner       = owner_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_bfly_out_port_sched.sv
// Testbench for bfly_out_port_sched: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model of the scheduling rules.
module tb_bfly_out_port_sched;

    localparam int PORTS       = 4;
    localparam int MAX_PAYLOAD = 15;
    localparam int PRI_BURST   = 3;
    localparam logic [1:0] RADR = 2'd2;
    localparam logic [3:0] PAY  = 4'b1000;
    localparam logic [3:0] NUL  = 4'b0000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [1:0]            r_adr;
    logic [PORTS-1:0][3:0] msn;
    logic [PORTS-1:0]      pri;
    logic                  rdy;
    logic [PORTS-1:0]      sel;
    logic                  shift;
    logic                  busy;
    logic [1:0]            owner;
    logic                  timeout_err;

    bfly_out_port_sched #(
        .PORTS(PORTS), .MAX_PAYLOAD(MAX_PAYLOAD), .PRI_BURST(PRI_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .r_adr(r_adr), .in_ch_hdr_msn(msn),
        .priority_field(pri), .out_ready(rdy), .sel(sel), .shift(shift),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Per-channel flit streams; head is presented each cycle.
    logic [3:0] q[4][$];

    // Reference model state (current and next).
    bit m_busy, n_busy, m_terr, n_terr;
    int m_owner, n_owner, m_rr, n_rr, m_pcnt, n_pcnt, m_cnt, n_cnt;

    logic [3:0] e_sel, o_sel;
    logic       e_shift, o_shift;
    logic [8:0] obs_vec, exp_vec;

    function automatic logic [3:0] hdr(input logic [1:0] d);
        return {2'b11, d};
    endfunction

    // Behavioural model: which channel should be selected this cycle and what the port becomes.
    task automatic model_comb();
        bit is_req[4];
        bit any_p, any_n, take_p;
        int win, c;
        e_sel = '0; e_shift = 1'b0;
        n_busy = m_busy; n_owner = m_owner; n_rr = m_rr;
        n_pcnt = m_pcnt; n_cnt = m_cnt; n_terr = 1'b0;
        any_p = 1'b0; any_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            is_req[i] = (int'(msn[i]) >= 12) && ((int'(msn[i]) % 4) == int'(r_adr));
            if (is_req[i] && pri[i])  any_p = 1'b1;
            if (is_req[i] && !pri[i]) any_n = 1'b1;
        end
        if (!m_busy) begin
            if (rdy && (any_p || any_n)) begin
                take_p = any_p && ((m_pcnt < PRI_BURST) || !any_n);
                win = -1;
                for (int k = 0; k < 4; k++) begin
                    c = (m_rr + k) % 4;
                    if (win < 0 && is_req[c] && (bit'(pri[c]) == take_p)) win = c;
                end
                e_sel[win] = 1'b1;
                e_shift    = 1'b1;
                n_busy = 1'b1; n_owner = win; n_rr = (win + 1) % 4; n_cnt = 0;
                if (take_p && any_n) n_pcnt = (m_pcnt + 1 > PRI_BURST) ? PRI_BURST : m_pcnt + 1;
                else                 n_pcnt = 0;
            end
        end else if (int'(msn[m_owner]) / 4 == 2) begin
            if (rdy) begin
                e_sel[m_owner] = 1'b1;
                n_cnt = m_cnt + 1;
                if (n_cnt == MAX_PAYLOAD) begin
                    n_busy = 1'b0;
                    n_terr = 1'b1;
                end
            end
        end else begin
            n_busy = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_rr = 0; m_pcnt = 0; m_cnt = 0; m_terr = 1'b0;
    endtask

    // One clock cycle: present heads, sample comb outputs, advance model and streams.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 4; i++) msn[i] = (q[i].size() > 0) ? q[i][0] : NUL;
        #1;
        model_comb();
        o_sel   = sel;
        o_shift = shift;
        @(posedge clk);
        m_busy = n_busy; m_owner = n_owner; m_rr = n_rr;
        m_pcnt = n_pcnt; m_cnt = n_cnt; m_terr = n_terr;
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0) begin
                if (e_sel[i] || (q[i][0][3:2] != 2'b11 && rdy)) void'(q[i].pop_front());
            end
        end
        #1;
        obs_vec = {o_sel, o_shift, busy, owner, timeout_err};
        exp_vec = {e_sel, e_shift, m_busy, 2'(m_owner), m_terr};
    endtask

    function automatic bit streams_empty();
        return (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0) && (q[3].size() == 0);
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; rdy = 1'b0; pri = '0; msn = '0;
        for (int i = 0; i < 4; i++) q[i].delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        r_adr = RADR; rdy = 1'b1; pri = '0;
        msn = '0; msn[0] = hdr(RADR); msn[2] = hdr(RADR);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, shift, busy, owner, timeout_err} !== 9'b0) begin
            failures++;
            $display("FAIL reset_assert got=%b want=%b", {sel, shift, busy, owner, timeout_err}, 9'b0);
        end
        @(posedge clk); #1;
        checks++;
        if ({sel, shift, busy, owner, timeout_err} !== 9'b0) begin
            failures++;
            $display("FAIL reset_hold got=%b want=%b", {sel, shift, busy, owner, timeout_err}, 9'b0);
        end
        apply_reset();
    endtask

    task automatic test_round_robin();
        int grants[$];
        int sel_cnt[4];
        int shift_cnt[4];
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            sel_cnt[i] = 0; shift_cnt[i] = 0;
            repeat (2) begin
                q[i].push_back(hdr(RADR)); q[i].push_back(PAY);
                q[i].push_back(PAY);       q[i].push_back(NUL);
            end
        end
        rdy = 1'b1;
        for (int c = 0; c < 60 && !(streams_empty() && !m_busy); c++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL rr_cycle%0d got=%b want=%b", c, obs_vec, exp_vec);
            end
            for (int i = 0; i < 4; i++) begin
                if (o_sel[i]) sel_cnt[i]++;
                if (o_sel[i] && o_shift) begin
                    shift_cnt[i]++;
                    grants.push_back(i);
                end
            end
        end
        checks++;
        if (!streams_empty()) begin
            failures++;
            $display("FAIL rr_budget got=undrained want=drained");
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= grants.size() || grants[k] != k % 4) begin
                failures++;
                $display("FAIL rr_order%0d got=%0d want=%0d", k, (k < grants.size()) ? grants[k] : -1, k % 4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sel_cnt[i] != 6 || shift_cnt[i] != 2) begin
                failures++;
                $display("FAIL rr_counts ch%0d got=sel%0d/shift%0d want=sel6/shift2", i, sel_cnt[i], shift_cnt[i]);
            end
        end
    endtask

    task automatic test_priority_starvation();
        int grants[$];
        int want[8] = '{1, 2, 1, 0, 1, 2, 1, 0};
        apply_reset();
        pri = 4'b0110;
        repeat (4) begin q[1].push_back(hdr(RADR)); q[1].push_back(PAY); q[1].push_back(NUL); end
        repeat (2) begin q[2].push_back(hdr(RADR)); q[2].push_back(PAY); q[2].push_back(NUL); end
        repeat (2) begin q[0].push_back(hdr(RADR)); q[0].push_back(PAY); q[0].push_back(NUL); end
        rdy = 1'b1;
        for (int c = 0; c < 80 && !(streams_empty() && !m_busy); c++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL pri_cycle%0d got=%b want=%b", c, obs_vec, exp_vec);
            end
            for (int i = 0; i < 4; i++) if (o_sel[i] && o_shift) grants.push_back(i);
        end
        checks++;
        if (grants.size() != 8) begin
            failures++;
            $display("FAIL pri_grant_count got=%0d want=8", grants.size());
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (k >= grants.size() || grants[k] != want[k]) begin
                failures++;
                $display("FAIL pri_order%0d got=%0d want=%0d", k, (k < grants.size()) ? grants[k] : -1, want[k]);
            end
        end
    endtask

    task automatic test_hold_ignore();
        int own3 = 0;
        int ch0_first = -1;
        apply_reset();
        q[3].push_back(hdr(RADR));
        repeat (5) q[3].push_back(PAY);
        q[3].push_back(NUL);
        q[0].push_back(NUL); q[0].push_back(hdr(RADR)); q[0].push_back(PAY); q[0].push_back(NUL);
        rdy = 1'b1;
        for (int c = 0; c < 30 && !(streams_empty() && !m_busy); c++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL hold_cycle%0d got=%b want=%b", c, obs_vec, exp_vec);
            end
            if (o_sel == 4'b1000) own3++;
            if (o_sel[0] && ch0_first < 0) ch0_first = c;
        end
        checks++;
        if (own3 != 6) begin
            failures++;
            $display("FAIL hold_sel3_cycles got=%0d want=6", own3);
        end
        checks++;
        if (ch0_first != 7) begin
            failures++;
            $display("FAIL hold_ch0_grant_cycle got=%0d want=7", ch0_first);
        end
    endtask

    task automatic test_backpressure();
        bit rdy_tab[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int fwd = 0;
        apply_reset();
        q[1].push_back(hdr(RADR));
        repeat (4) q[1].push_back(PAY);
        q[1].push_back(NUL);
        for (int c = 0; c < 10; c++) begin
            rdy = rdy_tab[c];
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL bp_cycle%0d got=%b want=%b", c, obs_vec, exp_vec);
            end
            if (c >= 2 && c <= 4) begin
                checks++;
                if (o_sel !== 4'b0000 || busy !== 1'b1 || owner !== 2'd1) begin
                    failures++;
                    $display("FAIL bp_stall%0d got=sel%b/busy%b/owner%0d want=sel0000/busy1/owner1", c, o_sel, busy, owner);
                end
            end
            if (o_sel == 4'b0010 && !o_shift) fwd++;
        end
        checks++;
        if (fwd != 4) begin
            failures++;
            $display("FAIL bp_forwarded got=%0d want=4", fwd);
        end
    endtask

    task automatic test_watchdog();
        int fwd = 0, pulses = 0, dropped = 0;
        apply_reset();
        q[1].push_back(hdr(RADR));
        repeat (20) q[1].push_back(PAY);
        q[1].push_back(NUL);
        rdy = 1'b1;
        for (int c = 0; c < 40 && !(streams_empty() && !m_busy); c++) begin
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL wd_cycle%0d got=%b want=%b", c, obs_vec, exp_vec);
            end
            if (o_sel == 4'b0010 && !o_shift) fwd++;
            if (msn[1] == PAY && o_sel == 4'b0000) dropped++;
            if (timeout_err) begin
                pulses++;
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL wd_busy_after got=%b want=0", busy);
                end
            end
        end
        checks++;
        if (fwd != MAX_PAYLOAD || pulses != 1 || dropped != 5) begin
            failures++;
            $display("FAIL wd_summary got=fwd%0d/pulses%0d/dropped%0d want=fwd15/pulses1/dropped5", fwd, pulses, dropped);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        q[2].push_back(hdr(RADR));
        repeat (3) q[2].push_back(PAY);
        q[2].push_back(NUL);
        rdy = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b1 || owner !== 2'd2) begin
            failures++;
            $display("FAIL ar_precond got=busy%b/owner%0d want=busy1/owner2", busy, owner);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, shift, busy, owner, timeout_err} !== 9'b0) begin
            failures++;
            $display("FAIL ar_immediate got=%b want=%b", {sel, shift, busy, owner, timeout_err}, 9'b0);
        end
        model_reset();
        for (int i = 0; i < 4; i++) q[i].delete();
        msn = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q[3].push_back(hdr(RADR));
        q[2].push_back(hdr(RADR));
        step();
        checks++;
        if (obs_vec !== exp_vec || o_sel !== 4'b0100) begin
            failures++;
            $display("FAIL ar_regrant got=%b want=%b", obs_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        int r;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                q[i].delete();
                r = $urandom_range(0, 9);
                if (c >= 100 && c < 200) r = (r < 2) ? r : 5;
                if (r < 4)
                    q[i].push_back(hdr(($urandom_range(0, 9) < 7) ? RADR : 2'($urandom)));
                else if (r < 8)
                    q[i].push_back(PAY);
                else
                    q[i].push_back({1'b0, 3'($urandom)});
            end
            pri = 4'($urandom);
            rdy = ($urandom_range(0, 4) != 0);
            step();
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL rand_cycle%0d got=%b want=%b", c, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        r_adr = RADR;
        msn   = '0;
        pri   = '0;
        rdy   = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_priority_starvation();
        test_hold_ignore();
        test_backpressure();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
